// File: rtl/mc_ctrl_fsm_if.sv
// Control bundle between the multi-cycle main FSM and the shared datapath.
// master: the controller (samples IR fields and flags, drives selects/enables).
// slave:  the datapath side (drives IR fields and flags, consumes controls).
interface mc_ctrl_fsm_if;
    logic [5:0] opcode;
    logic [5:0] funct;
    logic       zero;
    logic       mem_ready;
    logic [2:0] ALUOp;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic       ext_zero;
    logic       pc_write;
    logic [1:0] pc_src;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       reg_write;
    logic [1:0] reg_dst;
    logic [1:0] mem_to_reg;
    logic [3:0] state;
    logic       illegal;

    modport master (
        input  opcode, funct, zero, mem_ready,
        output ALUOp, alu_src_a, alu_src_b, ext_zero, pc_write, pc_src,
               iord, mem_read, mem_write, ir_write, reg_write, reg_dst,
               mem_to_reg, state, illegal
    );

    modport slave (
        output opcode, funct, zero, mem_ready,
        input  ALUOp, alu_src_a, alu_src_b, ext_zero, pc_write, pc_src,
               iord, mem_read, mem_write, ir_write, reg_write, reg_dst,
               mem_to_reg, state, illegal
    );
endinterface

// File: rtl/mc_ctrl_fsm.sv
// Multi-cycle main control FSM for the MIPS core.
// Sequences FETCH/DECODE/EXEC/MEM/WB and drives ALUOp plus all datapath
// selects and enables as Moore outputs (opcode/zero refine some states).
// Optional build macro: MC_MEM_WAIT_EN -- FETCH, MEM_RD and MEM_WR hold
// until mem_ready=1; without it mem_ready is ignored.
module mc_ctrl_fsm #(
    parameter int unsigned ST_W = 4
) (
    input  logic          clk,
    input  logic          reset,
    mc_ctrl_fsm_if.master ctl
);

    typedef enum logic [ST_W-1:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEM_ADDR = 4'd2,
        S_MEM_RD   = 4'd3,
        S_MEM_WB   = 4'd4,
        S_MEM_WR   = 4'd5,
        S_EXEC_R   = 4'd6,
        S_WB_R     = 4'd7,
        S_BRANCH   = 4'd8,
        S_EXEC_I   = 4'd9,
        S_WB_I     = 4'd10,
        S_JUMP     = 4'd11,
        S_JR       = 4'd12,
        S_ILLEGAL  = 4'd15
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_XORI  = 6'b001110;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] FN_JR    = 6'b001000;

    state_t state_q;
    state_t state_d;
    logic   mem_go;

`ifdef MC_MEM_WAIT_EN
    // Memory states advance only on the memory acknowledge.
    assign mem_go = ctl.mem_ready;
`else
    // mem_ready is ignored: every memory state completes in one cycle.
    assign mem_go = ctl.mem_ready | 1'b1;
`endif

    assign ctl.state = state_q;

    // State register: async reset aborts any instruction and returns to FETCH.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state decode.
    always_comb begin
        state_d = S_ILLEGAL;
        case (state_q)
            S_FETCH:    state_d = mem_go ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (ctl.opcode)
                    OP_RTYPE: state_d = (ctl.funct == FN_JR) ? S_JR : S_EXEC_R;
                    OP_LW, OP_SW: state_d = S_MEM_ADDR;
                    OP_BEQ, OP_BNE: state_d = S_BRANCH;
                    OP_ADDI, OP_ANDI, OP_ORI, OP_XORI, OP_LUI: state_d = S_EXEC_I;
                    OP_J, OP_JAL: state_d = S_JUMP;
                    default:  state_d = S_ILLEGAL;
                endcase
            end
            S_MEM_ADDR: state_d = (ctl.opcode == OP_SW) ? S_MEM_WR : S_MEM_RD;
            S_MEM_RD:   state_d = mem_go ? S_MEM_WB : S_MEM_RD;
            S_MEM_WB:   state_d = S_FETCH;
            S_MEM_WR:   state_d = mem_go ? S_FETCH : S_MEM_WR;
            S_EXEC_R:   state_d = S_WB_R;
            S_WB_R:     state_d = S_FETCH;
            S_BRANCH:   state_d = S_FETCH;
            S_EXEC_I:   state_d = S_WB_I;
            S_WB_I:     state_d = S_FETCH;
            S_JUMP:     state_d = S_FETCH;
            S_JR:       state_d = S_FETCH;
            S_ILLEGAL:  state_d = S_ILLEGAL;
            default:    state_d = S_ILLEGAL;
        endcase
    end

    // Output decode; everything is held inactive while reset is asserted.
    always_comb begin
        ctl.ALUOp      = 3'b000;
        ctl.alu_src_a  = 1'b0;
        ctl.alu_src_b  = 2'b00;
        ctl.ext_zero   = 1'b0;
        ctl.pc_write   = 1'b0;
        ctl.pc_src     = 2'b00;
        ctl.iord       = 1'b0;
        ctl.mem_read   = 1'b0;
        ctl.mem_write  = 1'b0;
        ctl.ir_write   = 1'b0;
        ctl.reg_write  = 1'b0;
        ctl.reg_dst    = 2'b00;
        ctl.mem_to_reg = 2'b00;
        ctl.illegal    = 1'b0;
        if (!reset) begin
            case (state_q)
                S_FETCH: begin
                    ctl.mem_read  = 1'b1;
                    ctl.ir_write  = mem_go;
                    ctl.pc_write  = mem_go;
                    ctl.alu_src_b = 2'b01;
                end
                S_DECODE: begin
                    ctl.alu_src_b = 2'b11;
                end
                S_MEM_ADDR: begin
                    ctl.alu_src_a = 1'b1;
                    ctl.alu_src_b = 2'b10;
                end
                S_MEM_RD: begin
                    ctl.mem_read = 1'b1;
                    ctl.iord     = 1'b1;
                end
                S_MEM_WB: begin
                    ctl.reg_write  = 1'b1;
                    ctl.mem_to_reg = 2'b01;
                end
                S_MEM_WR: begin
                    ctl.mem_write = 1'b1;
                    ctl.iord      = 1'b1;
                end
                S_EXEC_R: begin
                    ctl.alu_src_a = 1'b1;
                    ctl.ALUOp     = 3'b010;
                end
                S_WB_R: begin
                    ctl.reg_write = 1'b1;
                    ctl.reg_dst   = 2'b01;
                end
                S_BRANCH: begin
                    ctl.alu_src_a = 1'b1;
                    ctl.ALUOp     = 3'b001;
                    ctl.pc_src    = 2'b01;
                    ctl.pc_write  = (ctl.opcode == OP_BNE) ? !ctl.zero : ctl.zero;
                end
                S_EXEC_I: begin
                    ctl.alu_src_a = 1'b1;
                    ctl.alu_src_b = 2'b10;
                    case (ctl.opcode)
                        OP_ANDI: begin ctl.ALUOp = 3'b100; ctl.ext_zero = 1'b1; end
                        OP_ORI:  begin ctl.ALUOp = 3'b101; ctl.ext_zero = 1'b1; end
                        OP_XORI: begin ctl.ALUOp = 3'b110; ctl.ext_zero = 1'b1; end
                        OP_LUI:  ctl.ALUOp = 3'b111;
                        default: ctl.ALUOp = 3'b011;
                    endcase
                end
                S_WB_I: begin
                    ctl.reg_write = 1'b1;
                end
                S_JUMP: begin
                    ctl.pc_write = 1'b1;
                    ctl.pc_src   = 2'b10;
                    if (ctl.opcode == OP_JAL) begin
                        ctl.reg_write  = 1'b1;
                        ctl.reg_dst    = 2'b10;
                        ctl.mem_to_reg = 2'b10;
                    end
                end
                S_JR: begin
                    ctl.pc_write = 1'b1;
                    ctl.pc_src   = 2'b11;
                end
                S_ILLEGAL: begin
                    ctl.illegal = 1'b1;
                end
                default: begin
                    ctl.illegal = 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// Self-checking bench for mc_ctrl_fsm: per-cycle expected control words are
// queued when an instruction is issued and compared on each falling edge.
module tb_mc_ctrl_fsm;

    logic clk;
    logic reset;
    mc_ctrl_fsm_if bus ();

    mc_ctrl_fsm #(.ST_W(4)) dut (
        .clk   (clk),
        .reset (reset),
        .ctl   (bus)
    );

    typedef struct {
        string       tag;
        logic [31:0] v;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] obs();
        return {8'h00, bus.state, bus.ALUOp, bus.alu_src_a, bus.alu_src_b, bus.ext_zero,
                bus.pc_write, bus.pc_src, bus.iord, bus.mem_read, bus.mem_write,
                bus.ir_write, bus.reg_write, bus.reg_dst, bus.mem_to_reg, bus.illegal};
    endfunction

    // Field order: state, ALUOp, a, b, ext_zero, pc_write, pc_src, iord,
    // mem_read, mem_write, ir_write, reg_write, reg_dst, mem_to_reg, illegal.
    task automatic p(input string tag, input int st, input int alu, input int a, input int b,
                     input int ez, input int pw, input int ps, input int io, input int mr,
                     input int mw, input int irw, input int rw, input int rd, input int m2r,
                     input int ill);
        exp_t e;
        e.tag = tag;
        e.v = {8'h00, 4'(st), 3'(alu), 1'(a), 2'(b), 1'(ez), 1'(pw), 2'(ps), 1'(io),
               1'(mr), 1'(mw), 1'(irw), 1'(rw), 2'(rd), 2'(m2r), 1'(ill)};
        q.push_back(e);
    endtask

    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            chk($sformatf("%s@%0t", e.tag, $time), obs(), e.v);
        end
    end

    task automatic advance(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [5:0] op, input logic [5:0] fn, input logic z);
        bus.opcode = op;
        bus.funct  = fn;
        bus.zero   = z;
    endtask

    task automatic p_fetch();  p("fetch",  0, 0, 0, 1, 0, 1, 0, 0, 1, 0, 1, 0, 0, 0, 0); endtask
    task automatic p_decode(); p("decode", 1, 0, 0, 3, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0); endtask

    task automatic do_rtype(input logic [5:0] fn);
        issue(6'b000000, fn, 1'b0);
        p_fetch(); p_decode();
        p("exec_r", 6, 2, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        p("wb_r",   7, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0);
        advance(4);
    endtask

    task automatic do_lw();
        issue(6'b100011, 6'h00, 1'b0);
        p_fetch(); p_decode();
        p("mem_addr", 2, 0, 1, 2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        p("mem_rd",   3, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0);
        p("mem_wb",   4, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0);
        advance(5);
    endtask

    task automatic do_sw();
        issue(6'b101011, 6'h00, 1'b0);
        p_fetch(); p_decode();
        p("mem_addr", 2, 0, 1, 2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        p("mem_wr",   5, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0, 0, 0, 0, 0);
        advance(4);
    endtask

    task automatic do_branch(input logic [5:0] op, input logic z, input int pw);
        issue(op, 6'h00, z);
        p_fetch(); p_decode();
        p("branch", 8, 1, 1, 0, 0, pw, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        advance(3);
    endtask

    task automatic do_imm(input logic [5:0] op, input int alu, input int ez);
        issue(op, 6'h00, 1'b0);
        p_fetch(); p_decode();
        p("exec_i", 9,  alu, 1, 2, ez, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        p("wb_i",   10, 0,   0, 0, 0,  0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
        advance(4);
    endtask

    task automatic do_jump(input logic [5:0] op, input int jal);
        issue(op, 6'h00, 1'b0);
        p_fetch(); p_decode();
        p("jump", 11, 0, 0, 0, 0, 1, 2, 0, 0, 0, 0, jal, 2 * jal, 2 * jal, 0);
        advance(3);
    endtask

    task automatic do_jr();
        issue(6'b000000, 6'b001000, 1'b0);
        p_fetch(); p_decode();
        p("jr", 12, 0, 0, 0, 0, 1, 3, 0, 0, 0, 0, 0, 0, 0, 0);
        advance(3);
    endtask

    // Assert reset after this cycle's sample, check the idle outputs, release.
    task automatic reset_now(input string tag);
        reset = 1'b1;
        #1;
        chk({tag, "_state"}, 32'(bus.state), 32'd0);
        chk({tag, "_rw"}, 32'(bus.reg_write), 32'd0);
        chk({tag, "_all"}, obs(), 32'h0);
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog q=%0d", q.size());
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b1;
        issue(6'h00, 6'h00, 1'b0);
        bus.mem_ready = 1'b1;
        advance(3);
        chk("rst_idle", obs(), 32'h0);
        reset = 1'b0;

        do_rtype(6'b100000);
        do_lw();
        do_sw();
        do_branch(6'b000100, 1'b1, 1);
        do_branch(6'b000101, 1'b1, 0);
        do_branch(6'b000100, 1'b0, 0);
        do_branch(6'b000101, 1'b0, 1);
        do_imm(6'b001000, 3, 0);
        do_imm(6'b001100, 4, 1);
        do_imm(6'b001101, 5, 1);
        do_imm(6'b001110, 6, 1);
        do_imm(6'b001111, 7, 0);
        do_jump(6'b000010, 0);
        do_jump(6'b000011, 1);
        do_jr();

        // Abort mid-EXEC_R.
        issue(6'b000000, 6'b100000, 1'b0);
        p_fetch(); p_decode();
        p("exec_r", 6, 2, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        advance(2);
        #6;
        reset_now("abort_exec");
        do_rtype(6'b100010);

        // Abort in WB_R: the register write must drop with reset.
        issue(6'b000000, 6'b100000, 1'b0);
        p_fetch(); p_decode();
        p("exec_r", 6, 2, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        p("wb_r",   7, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0);
        advance(3);
        #6;
        reset_now("abort_wb");

        // Illegal opcode is sticky.
        issue(6'b111111, 6'h00, 1'b0);
        p_fetch(); p_decode();
        for (int i = 0; i < 10; i++)
            p("illegal", 15, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        advance(12);
        reset_now("exit_illegal");
        do_lw();

`ifdef MC_MEM_WAIT_EN
        // FETCH held by memory: no IR/PC update until mem_ready rises.
        bus.mem_ready = 1'b0;
        issue(6'b000000, 6'b100000, 1'b0);
        for (int i = 0; i < 3; i++)
            p("fetch_wait", 0, 0, 0, 1, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0);
        advance(3);
        bus.mem_ready = 1'b1;
        p_fetch(); p_decode();
        p("exec_r", 6, 2, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        p("wb_r",   7, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0);
        advance(4);
`endif

        for (int i = 0; i < 20 && q.size() > 0; i++)
            @(posedge clk);
        if (q.size() != 0)
            chk("drain", 32'(q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
